spi_master_ctrl: RTL

SPI mode-0 transaction sequencer sitting directly upstream of `spi_tx`. Generates SCLK and active-low chip select from the system clock. Drives `spi_tx`'s load/enable/data inputs and captures MISO MSB-first into a receive register. Presents a start/busy/done handshake to the DAQ control logic, e.g. an ADC command/readback sequencer.

---
 rtl/spi_master_ctrl_if.sv | 34 +++
 rtl/spi_master_ctrl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/spi_master_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : spi_master_ctrl_if
// Brief    : Handshake, serial and spi_tx-side signals of spi_master_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
interface spi_master_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start_i;
    logic [WIDTH-1:0] tx_data_i;
    logic             MISO_i;
    logic             busy_o;
    logic             done_o;
    logic [WIDTH-1:0] rx_data_o;
    logic             SCLK_o;
    logic             CS_n_o;
    logic             tx_load_o;
    logic             tx_en_o;
    logic [WIDTH-1:0] tx_buffer_o;

    modport master (
        input  start_i, tx_data_i, MISO_i,
        output busy_o, done_o, rx_data_o, SCLK_o, CS_n_o,
               tx_load_o, tx_en_o, tx_buffer_o
    );

    modport slave (
        output start_i, tx_data_i, MISO_i,
        input  busy_o, done_o, rx_data_o, SCLK_o, CS_n_o,
               tx_load_o, tx_en_o, tx_buffer_o
    );
endinterface
`default_nettype wire

// File: rtl/spi_master_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : spi_master_ctrl
// Brief    : SPI mode-0 transaction sequencer: CS/SCLK timing, MISO capture,
//            start/busy/done handshake and spi_tx load/enable drive.
// Revision : 1.0 - initial release
// ============================================================================
module spi_master_ctrl #(
    parameter int WIDTH    = 8,   // bits per transaction, >= 2
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2,
    parameter int CS_IDLE  = 2
) (
    input  logic               clock_i,
    input  logic               reset_ni,
    spi_master_ctrl_if.master  bus
);

    localparam int c_DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int c_WAIT_MX0 = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
    localparam int c_WAIT_MAX = (c_WAIT_MX0 > CS_IDLE) ? c_WAIT_MX0 : CS_IDLE;
    localparam int c_WAIT_W   = (c_WAIT_MAX > 1) ? $clog2(c_WAIT_MAX) : 1;
    localparam int c_BIT_W    = $clog2(WIDTH + 1);

    localparam logic [c_DIV_W-1:0]  c_DIV_LAST   = c_DIV_W'(CLK_DIV - 1);
    localparam logic [c_WAIT_W-1:0] c_SETUP_LAST = c_WAIT_W'(CS_SETUP - 1);
    localparam logic [c_WAIT_W-1:0] c_HOLD_LAST  = c_WAIT_W'(CS_HOLD - 1);
    localparam logic [c_WAIT_W-1:0] c_IDLE_LAST  = c_WAIT_W'(CS_IDLE - 1);
    localparam logic [c_BIT_W-1:0]  c_BITS       = c_BIT_W'(WIDTH);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_SETUP = 3'd2,
        S_SHIFT = 3'd3,
        S_HOLD  = 3'd4,
        S_GAP   = 3'd5
    } state_t;

    state_t              r_state,     w_state;
    logic [c_DIV_W-1:0]  r_div_cnt,   w_div_cnt;
    logic [c_WAIT_W-1:0] r_wait_cnt,  w_wait_cnt;
    logic [c_BIT_W-1:0]  r_bit_cnt,   w_bit_cnt;
    logic [WIDTH-1:0]    r_shift,     w_shift;
    logic                r_busy,      w_busy;
    logic                r_done,      w_done;
    logic [WIDTH-1:0]    r_rx_data,   w_rx_data;
    logic                r_sclk,      w_sclk;
    logic                r_cs_n,      w_cs_n;
    logic                r_tx_load,   w_tx_load;
    logic                r_tx_en,     w_tx_en;
    logic [WIDTH-1:0]    r_tx_buffer, w_tx_buffer;
    logic [WIDTH-1:0]    w_shift_in;

    // MISO enters at the LSB so the first bit captured ends up as the MSB.
    assign w_shift_in = {r_shift[WIDTH-2:0], bus.MISO_i};

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_state     <= S_IDLE;
            r_div_cnt   <= '0;
            r_wait_cnt  <= '0;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_rx_data   <= '0;
            r_sclk      <= 1'b0;
            r_cs_n      <= 1'b1;
            r_tx_load   <= 1'b0;
            r_tx_en     <= 1'b0;
            r_tx_buffer <= '0;
        end else begin
            r_state     <= w_state;
            r_div_cnt   <= w_div_cnt;
            r_wait_cnt  <= w_wait_cnt;
            r_bit_cnt   <= w_bit_cnt;
            r_shift     <= w_shift;
            r_busy      <= w_busy;
            r_done      <= w_done;
            r_rx_data   <= w_rx_data;
            r_sclk      <= w_sclk;
            r_cs_n      <= w_cs_n;
            r_tx_load   <= w_tx_load;
            r_tx_en     <= w_tx_en;
            r_tx_buffer <= w_tx_buffer;
        end
    end

    always_comb begin
        w_state     = r_state;
        w_div_cnt   = r_div_cnt;
        w_wait_cnt  = r_wait_cnt;
        w_bit_cnt   = r_bit_cnt;
        w_shift     = r_shift;
        w_busy      = r_busy;
        w_done      = 1'b0;
        w_rx_data   = r_rx_data;
        w_sclk      = r_sclk;
        w_cs_n      = r_cs_n;
        w_tx_load   = 1'b0;
        w_tx_en     = r_tx_en;
        w_tx_buffer = r_tx_buffer;

        case (r_state)
            S_IDLE: begin
                if (bus.start_i) begin
                    w_tx_buffer = bus.tx_data_i;
                    w_busy      = 1'b1;
                    w_tx_load   = 1'b1;
                    w_state     = S_LOAD;
                end
            end
            S_LOAD: begin
                w_cs_n     = 1'b0;
                w_tx_en    = 1'b1;
                w_wait_cnt = '0;
                w_state    = S_SETUP;
            end
            S_SETUP: begin
                // The exit edge is also the first SCLK rise and first sample.
                if (r_wait_cnt == c_SETUP_LAST) begin
                    w_sclk    = 1'b1;
                    w_shift   = w_shift_in;
                    w_bit_cnt = c_BIT_W'(1);
                    w_div_cnt = '0;
                    w_state   = S_SHIFT;
                end else begin
                    w_wait_cnt = r_wait_cnt + c_WAIT_W'(1);
                end
            end
            S_SHIFT: begin
                if (r_div_cnt == c_DIV_LAST) begin
                    w_div_cnt = '0;
                    if (!r_sclk) begin
                        w_sclk    = 1'b1;
                        w_shift   = w_shift_in;
                        w_bit_cnt = r_bit_cnt + c_BIT_W'(1);
                    end else begin
                        w_sclk = 1'b0;
                        if (r_bit_cnt == c_BITS) begin
                            w_wait_cnt = '0;
                            w_state    = S_HOLD;
                        end
                    end
                end else begin
                    w_div_cnt = r_div_cnt + c_DIV_W'(1);
                end
            end
            S_HOLD: begin
                if (r_wait_cnt == c_HOLD_LAST) begin
                    w_cs_n     = 1'b1;
                    w_tx_en    = 1'b0;
                    w_rx_data  = r_shift;
                    w_done     = 1'b1;
                    w_wait_cnt = '0;
                    w_state    = S_GAP;
                end else begin
                    w_wait_cnt = r_wait_cnt + c_WAIT_W'(1);
                end
            end
            S_GAP: begin
                if (r_wait_cnt == c_IDLE_LAST) begin
                    w_busy  = 1'b0;
                    w_state = S_IDLE;
                end else begin
                    w_wait_cnt = r_wait_cnt + c_WAIT_W'(1);
                end
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    assign bus.busy_o      = r_busy;
    assign bus.done_o      = r_done;
    assign bus.rx_data_o   = r_rx_data;
    assign bus.SCLK_o      = r_sclk;
    assign bus.CS_n_o      = r_cs_n;
    assign bus.tx_load_o   = r_tx_load;
    assign bus.tx_en_o     = r_tx_en;
    assign bus.tx_buffer_o = r_tx_buffer;

endmodule
`default_nettype wire
